// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

    localparam int MIN_DW = 5;
    localparam int MAX_DW = 9;

endpackage

// File: rtl/uart_tx_frame_serializer_if.sv
// Host-side handshake and line-side outputs of the UART frame serializer.
interface uart_tx_frame_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Tick;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Ready;
    logic                  TX_OUT;
    logic                  Busy;
    logic                  Ser_Done;

    modport master (
        output Tick, P_DATA, Data_Valid,
        input  Ready, TX_OUT, Busy, Ser_Done
    );

    modport slave (
        input  Tick, P_DATA, Data_Valid,
        output Ready, TX_OUT, Busy, Ser_Done
    );
endinterface

// File: rtl/uart_parity_gen.sv
// Parity of one data word; odd parity inverts the plain XOR reduction.
module uart_parity_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  parity
);
    assign parity = (^data) ^ (PARITY_ODD != 0);
endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART TX frame engine: one-word holding register feeding a Tick-paced
// start/data/parity/stop serializer with back-to-back frame chaining.
module uart_tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
    uart_tx_frame_serializer_if.slave    bus
);
    localparam int                CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_WIDTH < MIN_DW || DATA_WIDTH > MAX_DW || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx_frame_serializer: DATA_WIDTH must be 5..9 and STOP_BITS 1..2");
    end

    tx_state_t             state;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  stop_cnt;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] data_word;
    logic                  tx_out;
    logic                  busy;
    logic                  ser_done;
    logic                  parity;
    logic                  accept;
    logic                  load_frame;
    logic                  shift_en;
    logic                  next_bit;
    logic [DATA_WIDTH-1:0] shifted;

    // Accept and frame load are mutually exclusive: they need opposite hold_valid.
    assign accept     = bus.Data_Valid & ~hold_valid;
    assign load_frame = bus.Tick & hold_valid &
                        ((state == IDLE) || (state == STOP && stop_cnt == LAST_STOP));
    assign shift_en   = bus.Tick & ((state == START) || (state == DATA));
    assign next_bit   = (MSB_FIRST != 0) ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
    assign shifted    = (MSB_FIRST != 0) ? {shift_reg[DATA_WIDTH-2:0], 1'b0}
                                         : {1'b0, shift_reg[DATA_WIDTH-1:1]};

    uart_parity_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .PARITY_ODD (PARITY_ODD)
    ) u_parity (
        .data   (data_word),
        .parity (parity)
    );

    // Data registers carry no reset; hold_valid alone says whether hold_reg is meaningful.
    always_ff @(posedge CLK) begin
        if (accept) begin
            hold_reg <= bus.P_DATA;
        end
        if (load_frame) begin
            shift_reg <= hold_reg;
            data_word <= hold_reg;
        end else if (shift_en) begin
            shift_reg <= shifted;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            hold_valid <= 1'b0;
            tx_out     <= UART_IDLE_LVL;
            busy       <= 1'b0;
            ser_done   <= 1'b0;
        end else begin
            ser_done <= 1'b0;
            if (accept) begin
                hold_valid <= 1'b1;
            end else if (load_frame) begin
                hold_valid <= 1'b0;
            end
            if (bus.Tick) begin
                case (state)
                    IDLE: begin
                        if (hold_valid) begin
                            tx_out <= UART_START_LVL;
                            busy   <= 1'b1;
                            state  <= START;
                        end
                    end
                    START: begin
                        tx_out  <= next_bit;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx_out <= parity;
                                state  <= PARITY;
                            end else begin
                                tx_out   <= UART_IDLE_LVL;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            tx_out  <= next_bit;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        tx_out   <= UART_IDLE_LVL;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                    STOP: begin
                        if (stop_cnt == LAST_STOP) begin
                            ser_done <= 1'b1;
                            if (hold_valid) begin
                                tx_out <= UART_START_LVL;
                                state  <= START;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        tx_out <= UART_IDLE_LVL;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.Ready    = ~hold_valid;
    assign bus.TX_OUT   = tx_out;
    assign bus.Busy     = busy;
    assign bus.Ser_Done = ser_done;
endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed scoreboard bench for uart_tx_frame_serializer over four parameter sets.
module tb_uart_tx_frame_serializer;

    typedef struct packed {
        logic tx;
        logic last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       dv;
    logic [8:0] pd;
    int         sel;
    int         checks = 0;
    int         errors = 0;
    exp_t       q[$];
    logic       prev_last;

    always #5 clk = ~clk;

    // 0: defaults  1: odd parity, 2 stops, MSB first  2: no parity  3: 5-bit words
    uart_tx_frame_serializer_if #(.DATA_WIDTH(8)) bus0 ();
    uart_tx_frame_serializer_if #(.DATA_WIDTH(8)) bus1 ();
    uart_tx_frame_serializer_if #(.DATA_WIDTH(8)) bus2 ();
    uart_tx_frame_serializer_if #(.DATA_WIDTH(5)) bus3 ();

    uart_tx_frame_serializer dut0 (.CLK(clk), .RST(rst), .bus(bus0));
    uart_tx_frame_serializer #(.PARITY_ODD(1), .STOP_BITS(2), .MSB_FIRST(1))
        dut1 (.CLK(clk), .RST(rst), .bus(bus1));
    uart_tx_frame_serializer #(.PARITY_EN(0)) dut2 (.CLK(clk), .RST(rst), .bus(bus2));
    uart_tx_frame_serializer #(.DATA_WIDTH(5)) dut3 (.CLK(clk), .RST(rst), .bus(bus3));

    assign bus0.Tick = tick;  assign bus0.Data_Valid = dv && sel == 0;  assign bus0.P_DATA = pd[7:0];
    assign bus1.Tick = tick;  assign bus1.Data_Valid = dv && sel == 1;  assign bus1.P_DATA = pd[7:0];
    assign bus2.Tick = tick;  assign bus2.Data_Valid = dv && sel == 2;  assign bus2.P_DATA = pd[7:0];
    assign bus3.Tick = tick;  assign bus3.Data_Valid = dv && sel == 3;  assign bus3.P_DATA = pd[4:0];

    logic tx_a [4];
    logic busy_a [4];
    logic rdy_a [4];
    logic done_a [4];
    assign tx_a[0] = bus0.TX_OUT;  assign busy_a[0] = bus0.Busy;  assign rdy_a[0] = bus0.Ready;  assign done_a[0] = bus0.Ser_Done;
    assign tx_a[1] = bus1.TX_OUT;  assign busy_a[1] = bus1.Busy;  assign rdy_a[1] = bus1.Ready;  assign done_a[1] = bus1.Ser_Done;
    assign tx_a[2] = bus2.TX_OUT;  assign busy_a[2] = bus2.Busy;  assign rdy_a[2] = bus2.Ready;  assign done_a[2] = bus2.Ser_Done;
    assign tx_a[3] = bus3.TX_OUT;  assign busy_a[3] = bus3.Busy;  assign rdy_a[3] = bus3.Ready;  assign done_a[3] = bus3.Ser_Done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %0h expected %0h", tag, sel, obs, exp);
        end
    endtask

    // Expected line level after each Tick of one frame, from the instance's parameters.
    function automatic void push_frame(input int s, input logic [8:0] w);
        int   dw  = (s == 3) ? 5 : 8;
        int   sb  = (s == 1) ? 2 : 1;
        bit   pen = (s != 2);
        bit   odd = (s == 1);
        bit   msb = (s == 1);
        logic b;
        logic par = 1'b0;
        q.push_back('{tx: 1'b0, last: 1'b0});
        for (int i = 0; i < dw; i++) begin
            b = msb ? w[dw-1-i] : w[i];
            par ^= b;
            q.push_back('{tx: b, last: 1'b0});
        end
        if (pen) q.push_back('{tx: par ^ odd, last: 1'b0});
        for (int k = 0; k < sb; k++) q.push_back('{tx: 1'b1, last: (k == sb - 1)});
    endfunction

    task automatic do_tick(input int gap);
        exp_t e;
        repeat (gap) begin
            @(posedge clk); #1;
            chk("done_between_ticks", done_a[sel], 1'b0);
        end
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("tx_bit", tx_a[sel], e.tx);
            chk("busy_in_frame", busy_a[sel], 1'b1);
            chk("ser_done", done_a[sel], prev_last);
            prev_last = e.last;
        end else begin
            chk("tx_idle", tx_a[sel], 1'b1);
            chk("busy_idle", busy_a[sel], 1'b0);
            chk("ser_done", done_a[sel], prev_last);
            prev_last = 1'b0;
        end
    endtask

    task automatic run_frames(input int gap);
        while (q.size() > 0) do_tick(gap);
        do_tick(gap);
    endtask

    task automatic send(input logic [8:0] w, input bit with_tick);
        chk("ready_before_accept", rdy_a[sel], 1'b1);
        pd   = w;
        dv   = 1'b1;
        tick = with_tick;
        @(posedge clk); #1;
        dv   = 1'b0;
        tick = 1'b0;
        pd   = 9'h1FF;
        chk("ready_after_accept", rdy_a[sel], 1'b0);
        if (with_tick) begin
            chk("no_start_same_tick", tx_a[sel], 1'b1);
            chk("no_busy_same_tick", busy_a[sel], 1'b0);
        end
        push_frame(sel, w);
    endtask

    initial begin
        rst = 1'b0; tick = 1'b0; dv = 1'b0; pd = '0; sel = 0; prev_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            chk("rst_tx", tx_a[s], 1'b1);
            chk("rst_busy", busy_a[s], 1'b0);
            chk("rst_ready", rdy_a[s], 1'b1);
            chk("rst_done", done_a[s], 1'b0);
        end
        rst = 1'b1;

        // Defaults, Tick every 16 clocks, 0xA5; idle Tick ignored first.
        sel = 0;
        do_tick(3);
        send(9'h0A5, 1'b0);
        run_frames(15);
        send(9'h00F, 1'b0);
        run_frames(3);

        // Odd parity, two stop bits, MSB first.
        sel = 1;
        send(9'h0A5, 1'b0);
        run_frames(3);
        send(9'h00F, 1'b0);
        run_frames(2);

        // No parity: 10-bit frame.
        sel = 2;
        send(9'h0A5, 1'b0);
        run_frames(3);

        // Back-to-back with two stop bits; second word accepted mid-frame.
        sel = 1;
        send(9'h055, 1'b0);
        do_tick(3);
        chk("ready_after_pull", rdy_a[sel], 1'b1);
        repeat (3) do_tick(3);
        send(9'h0AA, 1'b0);
        run_frames(3);

        // Reset during data bit 3 with the holding register full.
        sel = 0;
        send(9'h03C, 1'b0);
        repeat (5) do_tick(2);
        send(9'h0FF, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrst_tx", tx_a[sel], 1'b1);
        chk("midrst_busy", busy_a[sel], 1'b0);
        chk("midrst_ready", rdy_a[sel], 1'b1);
        chk("midrst_done", done_a[sel], 1'b0);
        q.delete();
        prev_last = 1'b0;
        do_tick(3);
        send(9'h081, 1'b0);
        run_frames(3);

        // 5-bit words, Tick every cycle, accept coincident with a Tick.
        sel = 3;
        send(9'h016, 1'b1);
        run_frames(0);
        send(9'h01F, 1'b1);
        run_frames(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
